// File: rtl/mc_sequencer_if.sv
// Control bundle between the multi-cycle sequencer and the processor top level.
// halt/mem_ready are level signals: halt is honoured only in FETCH, and MEM holds until mem_ready=1 is seen on an edge.
interface mc_sequencer_if #(
  parameter int OPCODE_W = 6,
  parameter int CNT_W    = 32
);
  logic                halt;
  logic [OPCODE_W-1:0] opcode;
  logic                mem_ready;
  logic [2:0]          state;
  logic                ir_write;
  logic                reg_read_en;
  logic                alu_en;
  logic                mem_en;
  logic                wb_en;
  logic                pc_write;
  logic                illegal_op;
  logic [CNT_W-1:0]    instret;

  modport master (
    output halt, opcode, mem_ready,
    input  state, ir_write, reg_read_en, alu_en, mem_en, wb_en,
           pc_write, illegal_op, instret
  );

  modport slave (
    input  halt, opcode, mem_ready,
    output state, ir_write, reg_read_en, alu_en, mem_en, wb_en,
           pc_write, illegal_op, instret
  );
endinterface

// File: rtl/mc_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with one-hot stage strobes
// and a retired-instruction counter.
module mc_sequencer #(
  parameter int OPCODE_W = 6,
  parameter int CNT_W    = 32
) (
  input  logic         clk,
  input  logic         reset,
  mc_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_ADDI   = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_LW     = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OP_LW_POI = OPCODE_W'(6);
  localparam logic [OPCODE_W-1:0] OP_SW     = OPCODE_W'(7);
  localparam logic [OPCODE_W-1:0] OP_BGT    = OPCODE_W'(8);
  localparam logic [OPCODE_W-1:0] OP_BNE    = OPCODE_W'(11);
  localparam logic [OPCODE_W-1:0] OP_JMP    = OPCODE_W'(12);
  localparam logic [OPCODE_W-1:0] OP_CALL   = OPCODE_W'(13);
  localparam logic [OPCODE_W-1:0] OP_PUSH   = OPCODE_W'(15);
  localparam logic [OPCODE_W-1:0] OP_POP    = OPCODE_W'(16);

  state_t              state_q, state_d;
  logic [OPCODE_W-1:0] ir_opcode;
  logic [CNT_W-1:0]    instret_q;
  logic                pc_write;
  logic                illegal_op;

  logic is_alu, is_load, is_sw, is_branch, is_jmp, is_stack, is_pop, is_illegal;

  // Instruction class is always taken from the latched opcode, never the live bus.
  always_comb begin
    is_alu     = (ir_opcode <= OP_ADDI);
    is_load    = (ir_opcode == OP_LW) || (ir_opcode == OP_LW_POI);
    is_sw      = (ir_opcode == OP_SW);
    is_branch  = (ir_opcode >= OP_BGT) && (ir_opcode <= OP_BNE);
    is_jmp     = (ir_opcode == OP_JMP);
    is_stack   = (ir_opcode >= OP_CALL) && (ir_opcode <= OP_PUSH);
    is_pop     = (ir_opcode == OP_POP);
    is_illegal = (ir_opcode > OP_POP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      ir_opcode <= '0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_FETCH && !bus.halt) begin
        ir_opcode <= bus.opcode;
      end
      if (pc_write && !is_illegal) begin
        instret_q <= instret_q + CNT_W'(1);
      end
    end
  end

  // pc_write marks the final cycle of every instruction; in MEM it waits for mem_ready.
  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    illegal_op = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (!bus.halt) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (is_jmp || is_illegal) begin
          state_d    = S_FETCH;
          pc_write   = 1'b1;
          illegal_op = is_illegal;
        end else if (is_stack || is_pop) begin
          state_d = S_MEM;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_branch) begin
          state_d  = S_FETCH;
          pc_write = 1'b1;
        end else if (is_alu) begin
          state_d = S_WB;
        end else begin
          state_d = S_MEM;
        end
      end
      S_MEM: begin
        if (bus.mem_ready) begin
          if (is_load || is_pop) begin
            state_d = S_WB;
          end else begin
            state_d  = S_FETCH;
            pc_write = 1'b1;
          end
        end
      end
      S_WB: begin
        state_d  = S_FETCH;
        pc_write = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // sw is decoded but needs no special case: EXEC falls through to MEM and MEM retires it.
  logic unused_class;
  assign unused_class = is_sw;

  assign bus.state       = state_q;
  assign bus.ir_write    = (state_q == S_FETCH) && !bus.halt;
  assign bus.reg_read_en = (state_q == S_DECODE);
  assign bus.alu_en      = (state_q == S_EXEC);
  assign bus.mem_en      = (state_q == S_MEM);
  assign bus.wb_en       = (state_q == S_WB);
  assign bus.pc_write    = pc_write;
  assign bus.illegal_op  = illegal_op;
  assign bus.instret     = instret_q;

endmodule

// File: tb/tb_mc_sequencer.sv
// Self-checking bench for mc_sequencer: directed vector table, corner sequences,
// and randomized instructions against a stage-path reference model.
module tb_mc_sequencer;

  logic clk = 1'b0;
  logic reset;
  logic reset_w;

  always #5 clk = ~clk;

  mc_sequencer_if #(.OPCODE_W(6), .CNT_W(32)) bus ();
  mc_sequencer_if #(.OPCODE_W(6), .CNT_W(2))  bus_w ();

  mc_sequencer #(.OPCODE_W(6), .CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  mc_sequencer #(.OPCODE_W(6), .CNT_W(2)) dut_w (
    .clk   (clk),
    .reset (reset_w),
    .bus   (bus_w)
  );

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_instret;
  int          model_path[$];

  typedef struct {
    int op;
    int waits;
    int exp_cycles;
    int exp_retire;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] pack_out();
    return {bus.state, bus.ir_write, bus.reg_read_en, bus.alu_en, bus.mem_en,
            bus.wb_en, bus.pc_write, bus.illegal_op};
  endfunction

  function automatic logic [9:0] exp_out(input int s, input bit ir, input bit last, input bit ill);
    return {3'(s), ir, (s == 1), (s == 2), (s == 3), (s == 4), last, ill};
  endfunction

  // Stage sequence of one instruction: 0=F 1=D 2=E 3=M 4=WB, MEM repeated for each wait.
  task automatic build_path(input int op, input int waits);
    model_path.delete();
    model_path.push_back(0);
    model_path.push_back(1);
    if (op <= 4) begin
      model_path.push_back(2); model_path.push_back(4);
    end else if (op <= 6) begin
      model_path.push_back(2);
      for (int k = 0; k <= waits; k++) model_path.push_back(3);
      model_path.push_back(4);
    end else if (op == 7) begin
      model_path.push_back(2);
      for (int k = 0; k <= waits; k++) model_path.push_back(3);
    end else if (op <= 11) begin
      model_path.push_back(2);
    end else if (op == 12) begin
      // jump retires in DECODE
    end else if (op <= 15) begin
      for (int k = 0; k <= waits; k++) model_path.push_back(3);
    end else if (op == 16) begin
      for (int k = 0; k <= waits; k++) model_path.push_back(3);
      model_path.push_back(4);
    end
  endtask

  task automatic run_instr(input int op, input int waits, output int cycles);
    int  s;
    int  mem_idx;
    bit  last;
    build_path(op, waits);
    cycles  = 0;
    mem_idx = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      s = (i < model_path.size()) ? model_path[i] : 0;
      bus.opcode = (i == 0) ? 6'(op) : 6'($urandom_range(0, 63));
      bus.halt   = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      if (s == 3) begin
        bus.mem_ready = (mem_idx == waits);
        mem_idx++;
      end else begin
        bus.mem_ready = 1'($urandom_range(0, 1));
      end
      #1;
      last = (i == model_path.size() - 1);
      check($sformatf("outputs op=%0d cyc=%0d", op, i), 64'(pack_out()),
            64'(exp_out(s, s == 0, last, (op > 16) && (s == 1))));
      check($sformatf("instret op=%0d cyc=%0d", op, i), 64'(bus.instret), 64'(exp_instret));
      @(posedge clk);
      #1;
      cycles++;
      if (last && op <= 16) exp_instret++;
      if (bus.state == 3'd0) break;
    end
    check($sformatf("path_len op=%0d", op), 64'(cycles), 64'(model_path.size()));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int cycles;
    int base;
    int op;

    vecs[0] = '{1,  0, 4, 1};
    vecs[1] = '{5,  3, 8, 1};
    vecs[2] = '{10, 0, 3, 1};
    vecs[3] = '{12, 0, 2, 1};
    vecs[4] = '{63, 0, 2, 0};
    vecs[5] = '{7,  2, 6, 1};
    vecs[6] = '{16, 1, 5, 1};
    vecs[7] = '{13, 0, 3, 1};
    vecs[8] = '{0,  0, 4, 1};
    vecs[9] = '{17, 0, 2, 0};

    reset         = 1'b1;
    reset_w       = 1'b1;
    bus.halt      = 1'b0;
    bus.opcode    = 6'd0;
    bus.mem_ready = 1'b1;
    bus_w.halt      = 1'b0;
    bus_w.opcode    = 6'd1;
    bus_w.mem_ready = 1'b1;
    exp_instret   = 0;

    // Reset values, then reset with halt high: reset wins and ir_write follows ~halt.
    @(negedge clk);
    #1;
    check("reset_outputs", 64'(pack_out()), 64'(exp_out(0, 1'b1, 1'b0, 1'b0)));
    check("reset_instret", 64'(bus.instret), 64'd0);
    bus.halt = 1'b1;
    #1;
    check("reset_halt_outputs", 64'(pack_out()), 64'(exp_out(0, 1'b0, 1'b0, 1'b0)));

    // Counter wrap on a narrow instance retiring back-to-back ADDs.
    @(negedge clk);
    reset_w = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      repeat (4) @(posedge clk);
      #1;
      check($sformatf("wrap_instret k=%0d", k), 64'(bus_w.instret), 64'(k % 4));
    end

    // Halt held from reset for five cycles.
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      check($sformatf("halt_hold cyc=%0d", k), 64'(pack_out()), 64'(exp_out(0, 1'b0, 1'b0, 1'b0)));
    end

    foreach (vecs[v]) begin
      base = exp_instret;
      run_instr(vecs[v].op, vecs[v].waits, cycles);
      check($sformatf("vec%0d_cycles", v), 64'(cycles), 64'(vecs[v].exp_cycles));
      check($sformatf("vec%0d_retire", v), 64'(bus.instret), 64'(base + vecs[v].exp_retire));
    end

    for (int n = 0; n < 60; n++) begin
      op = ($urandom_range(0, 9) == 0) ? int'($urandom_range(17, 63)) : int'($urandom_range(0, 16));
      run_instr(op, $urandom_range(0, 3), cycles);
    end

    // Reset asserted during EXEC of SW clears everything immediately.
    @(negedge clk);
    bus.opcode = 6'd7;
    bus.halt   = 1'b0;
    @(negedge clk);
    bus.opcode = 6'd0;
    @(negedge clk);
    #1;
    check("sw_in_exec", 64'(bus.state), 64'd2);
    reset    = 1'b1;
    bus.halt = 1'b0;
    #1;
    check("sw_reset_outputs", 64'(pack_out()), 64'(exp_out(0, 1'b1, 1'b0, 1'b0)));
    check("sw_reset_instret", 64'(bus.instret), 64'd0);
    exp_instret = 0;
    bus.halt = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_reset_state", 64'(pack_out()), 64'(exp_out(0, 1'b0, 1'b0, 1'b0)));
    run_instr(1, 0, cycles);
    check("post_reset_retire", 64'(bus.instret), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
